// File: rtl/board_ctrl_if.sv
// Command handshake bundle for the 8x8 board sequencer.
// master = host issuing rectangle commands, slave = board_ctrl.
interface board_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_row;
    logic [2:0] cmd_clm;
    logic [2:0] cmd_h;
    logic [2:0] cmd_w;
    logic       cmd_fill;

    modport master (
        output cmd_valid,
        output cmd_row,
        output cmd_clm,
        output cmd_h,
        output cmd_w,
        output cmd_fill,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_row,
        input  cmd_clm,
        input  cmd_h,
        input  cmd_w,
        input  cmd_fill,
        output cmd_ready
    );
endinterface

// File: rtl/board_ctrl.sv
// Rectangle fill/erase sequencer for the 8x8 board, one cell per clock.
// Optional full-row clearing after fills: define BOARD_CTRL_ROW_CLEAR_EN.
module board_ctrl (
    input  logic            clk,
    input  logic            rst,
    board_ctrl_if.slave     cmd,
    input  logic [7:0][7:0] board,
    output logic [2:0]      row_counter,
    output logic [2:0]      clm_counter,
    output logic            update,
    output logic            fill_erase,
    output logic            busy,
    output logic            done,
    output logic [3:0]      rows_cleared
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
`ifdef BOARD_CTRL_ROW_CLEAR_EN
        CHECK = 3'd2,
        CLEAR = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    state_t     state, state_n;
    logic [2:0] row_n, clm_n;
    logic [2:0] clm_start, clm_start_n;
    logic [2:0] row_end, row_end_n;
    logic [2:0] clm_end, clm_end_n;
    logic       fill_q, fill_n;
    logic       update_n, fe_n, busy_n, done_n;

`ifdef BOARD_CTRL_ROW_CLEAR_EN
    logic [2:0] chk_r, chk_n;
    logic [3:0] rc_q, rc_n;
    assign rows_cleared = rc_q;
`else
    logic unused_board;
    assign unused_board = ^board;
    assign rows_cleared = 4'd0;
`endif

    // 4-bit sum so a rectangle running off the board clips at 7
    function automatic logic [2:0] clip(input logic [2:0] a,
                                        input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[3] ? 3'd7 : s[2:0];
    endfunction

    assign cmd.cmd_ready = (state == IDLE);

    always_comb begin
        state_n     = state;
        row_n       = row_counter;
        clm_n       = clm_counter;
        clm_start_n = clm_start;
        row_end_n   = row_end;
        clm_end_n   = clm_end;
        fill_n      = fill_q;
        update_n    = 1'b0;
        fe_n        = fill_erase;
        busy_n      = busy;
        done_n      = 1'b0;
`ifdef BOARD_CTRL_ROW_CLEAR_EN
        chk_n       = chk_r;
        rc_n        = rc_q;
`endif
        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (cmd.cmd_valid) begin
                    state_n     = SCAN;
                    row_n       = cmd.cmd_row;
                    clm_n       = cmd.cmd_clm;
                    clm_start_n = cmd.cmd_clm;
                    row_end_n   = clip(cmd.cmd_row, cmd.cmd_h);
                    clm_end_n   = clip(cmd.cmd_clm, cmd.cmd_w);
                    fill_n      = cmd.cmd_fill;
                    update_n    = 1'b1;
                    fe_n        = cmd.cmd_fill;
                    busy_n      = 1'b1;
`ifdef BOARD_CTRL_ROW_CLEAR_EN
                    rc_n        = 4'd0;
`endif
                end
            end
            SCAN: begin
                if (clm_counter != clm_end) begin
                    clm_n    = clm_counter + 3'd1;
                    update_n = 1'b1;
                end else if (row_counter != row_end) begin
                    clm_n    = clm_start;
                    row_n    = row_counter + 3'd1;
                    update_n = 1'b1;
                end else begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
`ifdef BOARD_CTRL_ROW_CLEAR_EN
                    if (fill_q) begin
                        state_n = CHECK;
                        done_n  = 1'b0;
                        busy_n  = 1'b1;
                        chk_n   = 3'd0;
                    end
`endif
                end
            end
`ifdef BOARD_CTRL_ROW_CLEAR_EN
            CHECK: begin
                if (board[chk_r] == 8'hFF) begin
                    state_n  = CLEAR;
                    row_n    = chk_r;
                    clm_n    = 3'd0;
                    update_n = 1'b1;
                    fe_n     = 1'b0;
                end else if (chk_r == 3'd7) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    chk_n = chk_r + 3'd1;
                end
            end
            CLEAR: begin
                if (clm_counter != 3'd7) begin
                    clm_n    = clm_counter + 3'd1;
                    update_n = 1'b1;
                end else begin
                    rc_n = rc_q + 4'd1;
                    if (chk_r == 3'd7) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = CHECK;
                        chk_n   = chk_r + 3'd1;
                    end
                end
            end
`endif
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            row_counter <= 3'd0;
            clm_counter <= 3'd0;
            clm_start   <= 3'd0;
            row_end     <= 3'd0;
            clm_end     <= 3'd0;
            fill_q      <= 1'b0;
            update      <= 1'b0;
            fill_erase  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            row_counter <= row_n;
            clm_counter <= clm_n;
            clm_start   <= clm_start_n;
            row_end     <= row_end_n;
            clm_end     <= clm_end_n;
            fill_q      <= fill_n;
            update      <= update_n;
            fill_erase  <= fe_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

`ifdef BOARD_CTRL_ROW_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_r <= 3'd0;
            rc_q  <= 4'd0;
        end else begin
            chk_r <= chk_n;
            rc_q  <= rc_n;
        end
    end
`endif

endmodule

// File: tb/tb_board_ctrl.sv
// Directed self-checking bench for board_ctrl with a behavioural board.
// Expected values are hand-derived; row-clear cases run only with the macro.
module tb_board_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    board_ctrl_if bus ();

    logic [7:0][7:0] board;
    logic [2:0]      row_counter, clm_counter;
    logic            update, fill_erase, busy, done;
    logic [3:0]      rows_cleared;
    logic            load;
    logic [63:0]     load_val;

`ifdef BOARD_CTRL_ROW_CLEAR_EN
    localparam int CHK = 8;
`else
    localparam int CHK = 0;
`endif

    board_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (bus),
        .board        (board),
        .row_counter  (row_counter),
        .clm_counter  (clm_counter),
        .update       (update),
        .fill_erase   (fill_erase),
        .busy         (busy),
        .done         (done),
        .rows_cleared (rows_cleared)
    );

    always @(posedge clk) begin
        if (load)
            board <= load_val;
        else if (update)
            board[row_counter][clm_counter] <= fill_erase;
    end

    int checks = 0;
    int errors = 0;
    logic [6:0] q[$];
    int cyc;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] e(input logic [2:0] r,
                                     input logic [2:0] c,
                                     input logic f);
        return {r, c, f};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] r, input logic [2:0] c,
                        input logic [2:0] h, input logic [2:0] w,
                        input logic f, input logic keep);
        bus.cmd_row   = r;
        bus.cmd_clm   = c;
        bus.cmd_h     = h;
        bus.cmd_w     = w;
        bus.cmd_fill  = f;
        bus.cmd_valid = 1'b1;
        check("ready_before_accept", bus.cmd_ready, 1);
        step();
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    // Called one sample after the accept edge; cycle 1 is that sample.
    task automatic collect(output int n);
        q.delete();
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            if (update) q.push_back({row_counter, clm_counter, fill_erase});
            if (done) begin
                n = k;
                break;
            end
            step();
        end
        if (n == 0) check("done_timeout", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ii;
        bus.cmd_valid = 1'b0;
        bus.cmd_row   = 3'd0;
        bus.cmd_clm   = 3'd0;
        bus.cmd_h     = 3'd0;
        bus.cmd_w     = 3'd0;
        bus.cmd_fill  = 1'b0;
        load          = 1'b1;
        load_val      = 64'd0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_update", update, 0);
        check("rst_fe", fill_erase, 0);
        check("rst_row", row_counter, 0);
        check("rst_clm", clm_counter, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rc", rows_cleared, 0);
        load = 1'b0;
        rst  = 1'b0;
        step();

        // basic 2x3 fill
        send(3'd2, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0);
        check("t1_first_update", update, 1);
        collect(cyc);
        check("t1_done_cycle", cyc, 7 + CHK);
        check("t1_count", q.size(), 6);
        check("t1_c0", q[0], e(3'd2, 3'd3, 1'b1));
        check("t1_c1", q[1], e(3'd2, 3'd4, 1'b1));
        check("t1_c2", q[2], e(3'd2, 3'd5, 1'b1));
        check("t1_c3", q[3], e(3'd3, 3'd3, 1'b1));
        check("t1_c4", q[4], e(3'd3, 3'd4, 1'b1));
        check("t1_c5", q[5], e(3'd3, 3'd5, 1'b1));
        check("t1_busy_at_done", busy, 0);
        check("t1_rc", rows_cleared, 0);
        check("t1_board", board, 64'h0000_0000_3838_0000);
        step();
        check("t1_idle_ready", bus.cmd_ready, 1);
        check("t1_done_pulse", done, 0);

        // clipping at the bottom-right corner
        send(3'd6, 3'd6, 3'd7, 3'd7, 1'b1, 1'b0);
        collect(cyc);
        check("t2_done_cycle", cyc, 5 + CHK);
        check("t2_count", q.size(), 4);
        check("t2_c0", q[0], e(3'd6, 3'd6, 1'b1));
        check("t2_c1", q[1], e(3'd6, 3'd7, 1'b1));
        check("t2_c2", q[2], e(3'd7, 3'd6, 1'b1));
        check("t2_c3", q[3], e(3'd7, 3'd7, 1'b1));
        check("t2_board", board, 64'hC0C0_0000_3838_0000);
        step();

        // full-board erase
        load     = 1'b1;
        load_val = '1;
        step();
        load = 1'b0;
        send(3'd0, 3'd0, 3'd7, 3'd7, 1'b0, 1'b0);
        collect(cyc);
        check("t3_done_cycle", cyc, 65);
        check("t3_count", q.size(), 64);
        for (int i = 0; i < 64; i++) begin
            ii = i[5:0];
            check("t3_cell", q[i], e(ii[5:3], ii[2:0], 1'b0));
        end
        check("t3_board", board, 64'd0);
        check("t3_rc", rows_cleared, 0);
        step();

`ifdef BOARD_CTRL_ROW_CLEAR_EN
        // two full rows cleared after a column fill
        load     = 1'b1;
        load_val = 64'hFE00_00FE_0000_0000;
        step();
        load = 1'b0;
        send(3'd4, 3'd0, 3'd3, 3'd0, 1'b1, 1'b0);
        collect(cyc);
        check("t4_done_cycle", cyc, 29);
        check("t4_count", q.size(), 20);
        check("t4_s0", q[0], e(3'd4, 3'd0, 1'b1));
        check("t4_s3", q[3], e(3'd7, 3'd0, 1'b1));
        check("t4_clr_first", q[4], e(3'd4, 3'd0, 1'b0));
        check("t4_clr_r4_end", q[11], e(3'd4, 3'd7, 1'b0));
        check("t4_clr_r7_first", q[12], e(3'd7, 3'd0, 1'b0));
        check("t4_clr_last", q[19], e(3'd7, 3'd7, 1'b0));
        check("t4_rc", rows_cleared, 2);
        check("t4_board", board, 64'h0001_0100_0000_0000);
        step();
`endif

        // cmd_valid held through a command
        load     = 1'b1;
        load_val = 64'd0;
        step();
        load = 1'b0;
        send(3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1);
        bus.cmd_row  = 3'd5;
        bus.cmd_clm  = 3'd5;
        bus.cmd_h    = 3'd0;
        bus.cmd_w    = 3'd0;
        bus.cmd_fill = 1'b0;
        check("t5_ready_scan", bus.cmd_ready, 0);
        collect(cyc);
        check("t5_done_cycle", cyc, 3 + CHK);
        check("t5_count", q.size(), 2);
        check("t5_c0", q[0], e(3'd0, 3'd0, 1'b1));
        check("t5_c1", q[1], e(3'd0, 3'd1, 1'b1));
        check("t5_ready_done", bus.cmd_ready, 0);
        step();
        check("t5_ready_idle", bus.cmd_ready, 1);
        check("t5_idle_update", update, 0);
        step();
        bus.cmd_valid = 1'b0;
        check("t5_b_update", update, 1);
        check("t5_b_row", row_counter, 5);
        check("t5_b_clm", clm_counter, 5);
        check("t5_b_fe", fill_erase, 0);
        collect(cyc);
        check("t5_b_done_cycle", cyc, 2);
        check("t5_b_count", q.size(), 1);
        check("t5_board", board, 64'h0000_0000_0000_0003);
        step();

        // asynchronous reset mid-scan
        send(3'd0, 3'd0, 3'd7, 3'd7, 1'b1, 1'b0);
        step();
        step();
        step();
        check("t6_busy_pre", busy, 1);
        check("t6_update_pre", update, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_update", update, 0);
        check("t6_busy", busy, 0);
        check("t6_row", row_counter, 0);
        check("t6_clm", clm_counter, 0);
        check("t6_fe", fill_erase, 0);
        check("t6_ready", bus.cmd_ready, 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        step();
        send(3'd3, 3'd4, 3'd0, 3'd0, 1'b1, 1'b0);
        collect(cyc);
        check("t6_next_done_cycle", cyc, 2 + CHK);
        check("t6_next_count", q.size(), 1);
        check("t6_next_cell", q[0], e(3'd3, 3'd4, 1'b1));
        check("t6_row3", board[3], 8'h10);
        check("t6_row0", board[0], 8'h07);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_ctrl.md
# board_ctrl

Command sequencer for the 8x8 board datapath. Accepts rectangle fill/erase commands over a valid/ready handshake and walks the rectangle cell by cell, driving the board's `row_counter`, `clm_counter`, `update` and `fill_erase` inputs, one cell per clock. When enabled, it also detects full rows after a fill command and erases them. It sits between the game/host logic and the board storage.

## Interface

Parameters: none (board fixed at 8x8).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_row`  in  3  top row of the rectangle.
- `cmd_clm`  in  3  left column of the rectangle.
- `cmd_h`  in  3  height minus 1 (0 means 1 row).
- `cmd_w`  in  3  width minus 1 (0 means 1 column).
- `cmd_fill`  in  1  1 = fill, 0 = erase.
- `board`  in  8x[7:0]  current board contents; `board[r][c]` is the cell at row r, column c.
- `row_counter`  out  3  row address to the board.
- `clm_counter`  out  3  column address to the board.
- `update`  out  1  board write strobe.
- `fill_erase`  out  1  value to write (1 = fill, 0 = erase).
- `busy`  out  1  command in progress (not IDLE).
- `done`  out  1  one-cycle pulse when a command completes.
- `rows_cleared`  out  4  number of rows cleared by the last command.

## Operation

- States: IDLE, SCAN, CHECK, CLEAR, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch the command, clear `rows_cleared`, and go to SCAN.
- Rectangle bounds use 4-bit arithmetic:
  - `row_end` = min(`cmd_row` + `cmd_h`, 7).
  - `clm_end` = min(`cmd_clm` + `cmd_w`, 7).
  - Cells past the board edge are clipped. There is no wrap-around.
- SCAN:
  - `update`=1, `fill_erase`=latched `cmd_fill`.
  - Addresses step row-major from (`cmd_row`, `cmd_clm`) to (`row_end`, `clm_end`). The column increments; at `clm_end` it returns to `cmd_clm` and the row increments.
  - After the last cell: go to CHECK if `cmd_fill`=1 and ROW_CLEAR_EN is defined, otherwise go to DONE.
- CHECK (one cycle per row, r = 0..7):
  - `update`=0.
  - If `board[r]`==8'hFF, go to CLEAR for row r.
  - Otherwise advance r. After r=7, go to DONE.
- CLEAR:
  - 8 cycles, `row_counter`=r, `clm_counter`=0..7, `update`=1, `fill_erase`=0.
  - Then increment `rows_cleared`, return to CHECK at r+1 (DONE if r=7).
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `cmd_valid` is ignored outside IDLE. Command inputs need to be stable only in the accept cycle.
- Reset, including mid-command: immediately enter IDLE and abort the in-flight command. Cells already written stay written.

## Timing

- All outputs are registered, except `cmd_ready`, which is decoded from the state (IDLE).
- Values asserted during and after reset:
  - `cmd_ready`=1
  - `update`=0, `fill_erase`=0
  - `row_counter`=0, `clm_counter`=0
  - `busy`=0, `done`=0
  - `rows_cleared`=0
- Latency:
  - First `update` is the cycle after the accept edge.
  - A clipped rectangle of R rows x C columns occupies exactly R·C SCAN cycles.
  - `done` follows the last SCAN cycle by one cycle when no CHECK pass runs.
- CHECK pass: 8 + 8·k cycles, where k = number of full rows.
- The earliest next accept is the cycle after `done`; there is one IDLE cycle minimum.
- The board write from the last SCAN cycle is visible on `board` in the first CHECK cycle.
- `busy`=1 in SCAN, CHECK, CLEAR and DONE-entry; `busy`=0 in IDLE and DONE.

## Configuration

- `BOARD_CTRL_ROW_CLEAR_EN` defined: CHECK and CLEAR states are present, and full rows are erased after every fill command.
- `BOARD_CTRL_ROW_CLEAR_EN` undefined:
  - CHECK and CLEAR are compiled out.
  - SCAN always proceeds to DONE.
  - `rows_cleared` is tied to 0.

## Test plan

- Reset, then fill (row 2, clm 3, h 1, w 2): 6 `update` pulses at (2,3),(2,4),(2,5),(3,3),(3,4),(3,5) with `fill_erase`=1; `done` on the 7th cycle after accept; board bits set exactly there.
- Clipping: fill (row 6, clm 6, h 7, w 7) → 4 updates at (6,6),(6,7),(7,6),(7,7); no address wraps to 0.
- Erase (row 0, clm 0, h 7, w 7) over a full board → 64 updates with `fill_erase`=0; board all zero; `rows_cleared`=0 even with the macro defined.
- Macro defined, with rows 4 and 7 pre-filled except column 0: fill (row 4, clm 0, h 3, w 0) → rows 4 and 7 erased (16 CLEAR cycles), `rows_cleared`=2, row 5 and 6 column 0 remain set.
- `cmd_valid` held high during SCAN with a different command → ignored; `cmd_ready`=0 until IDLE; the second command is accepted only after `done`.
- Assert `rst` asynchronously in the middle of SCAN → `update`, `busy` and counters go to 0 without waiting for a clock edge; `cmd_ready`=1; the next command executes normally.
